// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, status bit positions and TX sequencer states.
package uart_pkg;

   localparam logic [1:0] UART_TX_REG_IN  = 2'b01;
   localparam logic [1:0] UART_RX_REG_OUT = 2'b10;
   localparam logic [1:0] UART_TX_REG_OUT = 2'b11;

   // RX_STAT bit positions; [7:0] carry the received byte
   localparam int RX_PAR_BIT   = 8;
   localparam int RX_PERR_BIT  = 9;
   localparam int RX_VALID_BIT = 10;
   localparam int RX_OVR_BIT   = 11;

   // TX_STAT bit positions; [7:0] carry the byte last handed to the engine
   localparam int TX_BUSY_BIT  = 8;
   localparam int TX_EMPTY_BIT = 9;
   localparam int TX_FULL_BIT  = 10;
   localparam int TX_OVF_BIT   = 11;
   localparam int TX_CNT_LSB   = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } tx_state_t;

   // Occupancy as it appears in the 4-bit TX_STAT count field.
   function automatic logic [3:0] cnt_field(input logic [31:0] c);
      return c[3:0];
   endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU data-bus view of the UART register block.
// Handshake: wr_en/rd_en are single-cycle strobes qualified by addr; rdata is combinational from addr.
interface uart_mmio_ctrl_if;
   logic        wr_en;
   logic        rd_en;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wr_en, rd_en, addr, wdata, input rdata);
   modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO of 9-bit TX entries ({parity_en, byte}); pointers wrap modulo DEPTH.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [8:0]       i_din,
   input  logic             i_pop,
   output logic [8:0]       o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [8:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A pop frees a slot in the same cycle, so a push to a full FIFO is accepted then.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART register block: queues CPU TX bytes to the TX engine via start/done and
// captures RX frames into a read-to-clear status register.
module uart_mmio_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   uart_mmio_ctrl_if.slave  bus,
   output logic [7:0]       tx_data,
   output logic             tx_parity_en,
   output logic             tx_start,
   input  logic             tx_done,
   input  logic [8:0]       rx_data,
   input  logic             rx_parity_err,
   input  logic             rx_done,
   output logic             irq,
   output tx_state_t        dbg_tx_state
);

   tx_state_t        r_state;
   logic             r_tx_start;
   logic [7:0]       r_tx_data;
   logic             r_tx_par;
   logic [8:0]       r_rx_data;
   logic             r_rx_perr;
   logic             r_rx_valid;
   logic             r_rx_overrun;
   logic             r_tx_overflow;

   logic [8:0]       w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_tx_wr;
   logic             w_pop;
   logic             w_tx_busy;
   logic             w_ovf_set;
   logic             w_rx_clr;
   logic             w_tx_stat_rd;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_unused     = ^bus.wdata[31:9];
   assign w_tx_wr      = bus.wr_en & (bus.addr == UART_TX_REG_IN);
   assign w_rx_clr     = bus.rd_en & (bus.addr == UART_RX_REG_OUT);
   assign w_tx_stat_rd = bus.rd_en & (bus.addr == UART_TX_REG_OUT);
   assign w_tx_busy    = (r_state != IDLE);
   assign w_pop        = (r_state == IDLE) & ~w_empty;
   assign w_ovf_set    = w_tx_wr & w_full & ~w_pop;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_tx_wr),
      .i_din   ({bus.wdata[8], bus.wdata[7:0]}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // TX sequencer; tx_start is high exactly while the state is START.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_tx_par   <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_tx_data  <= w_head[7:0];
                  r_tx_par   <= w_head[8];
                  r_tx_start <= 1'b1;
                  r_state    <= START;
               end
            end
            START:   r_state <= BUSY;
            BUSY:    if (tx_done) r_state <= GAP;
            GAP:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_overflow <= 1'b0;
      end else if (w_ovf_set) begin
         r_tx_overflow <= 1'b1;
      end else if (w_tx_stat_rd) begin
         r_tx_overflow <= 1'b0;
      end
   end

   // A clearing read in the same cycle as rx_done consumes the old byte, so no overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_data    <= '0;
         r_rx_perr    <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_rx_clr) r_rx_overrun <= 1'b0;
         if (rx_done) begin
            r_rx_data  <= rx_data;
            r_rx_perr  <= rx_parity_err;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !w_rx_clr) r_rx_overrun <= 1'b1;
         end else if (w_rx_clr) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.addr)
         UART_RX_REG_OUT: begin
            w_rdata[8:0]         = r_rx_data;
            w_rdata[RX_PERR_BIT]  = r_rx_perr;
            w_rdata[RX_VALID_BIT] = r_rx_valid;
            w_rdata[RX_OVR_BIT]   = r_rx_overrun;
         end
         UART_TX_REG_OUT: begin
            w_rdata[7:0]                = r_tx_data;
            w_rdata[TX_BUSY_BIT]         = w_tx_busy;
            w_rdata[TX_EMPTY_BIT]        = w_empty;
            w_rdata[TX_FULL_BIT]         = w_full;
            w_rdata[TX_OVF_BIT]          = r_tx_overflow;
            w_rdata[TX_CNT_LSB +: 4]     = cnt_field(32'(w_count));
         end
         default: w_rdata = '0;
      endcase
   end

   assign bus.rdata    = w_rdata;
   assign tx_data      = r_tx_data;
   assign tx_parity_en = r_tx_par;
   assign tx_start     = r_tx_start;
   assign irq          = r_rx_valid | (w_empty & ~w_tx_busy);
   assign dbg_tx_state = r_state;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: hand-computed register values plus a queue of
// bytes expected on each tx_start pulse.
module tb_uart_mmio_ctrl;
   import uart_pkg::*;

   logic        clk;
   logic        reset;
   logic [7:0]  tx_data;
   logic        tx_parity_en;
   logic        tx_start;
   logic        tx_done;
   logic [8:0]  rx_data;
   logic        rx_parity_err;
   logic        rx_done;
   logic        irq;
   tx_state_t   dbg_tx_state;

   int n_chk  = 0;
   int n_pass = 0;
   int n_start = 0;
   logic [8:0]  exp_q[$];
   logic [31:0] v;

   uart_mmio_ctrl_if bus ();

   uart_mmio_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .tx_data       (tx_data),
      .tx_parity_en  (tx_parity_en),
      .tx_start      (tx_start),
      .tx_done       (tx_done),
      .rx_data       (rx_data),
      .rx_parity_err (rx_parity_err),
      .rx_done       (rx_done),
      .irq           (irq),
      .dbg_tx_state  (dbg_tx_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.wr_en = 1'b1;
      cyc();
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      #1;
      d = bus.rdata;
      cyc();
      bus.rd_en = 1'b0;
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
   endtask

   task automatic rx_frame(input logic [8:0] d, input logic perr);
      rx_data       = d;
      rx_parity_err = perr;
      rx_done       = 1'b1;
      cyc();
      rx_done = 1'b0;
   endtask

   // Scoreboard: every start pulse must carry the next expected {parity_en, byte}.
   always @(negedge clk) begin
      if (reset && tx_start) begin
         n_start++;
         if (exp_q.size() == 0) check_val("tx_start_unexpected", 32'd1, 32'd0);
         else check_val("tx_byte", {23'd0, tx_parity_en, tx_data}, {23'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = UART_TX_REG_OUT;
      bus.wdata = '0;
      tx_done = 1'b0;
      rx_data = '0;
      rx_parity_err = 1'b0;
      rx_done = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;

      // Reset state
      peek(UART_TX_REG_OUT, v);
      check_val("rst_tx_stat", v, 32'h0000_0200);
      check_val("rst_irq", {31'd0, irq}, 32'd1);
      check_val("rst_state", 32'(dbg_tx_state), 32'(IDLE));
      peek(UART_RX_REG_OUT, v);
      check_val("rst_rx_stat", v, 32'h0);
      repeat (3) cyc();
      check_val("rst_no_start", 32'(n_start), 32'd0);

      // Single byte: start two cycles after the write strobe
      exp_q.push_back(9'h1A5);
      bus_write(UART_TX_REG_IN, 32'h0000_01A5);
      check_val("start_not_early", {31'd0, tx_start}, 32'd0);
      cyc();
      check_val("start_pulse", {31'd0, tx_start}, 32'd1);
      check_val("start_parity", {31'd0, tx_parity_en}, 32'd1);
      cyc();
      check_val("start_one_cycle", {31'd0, tx_start}, 32'd0);
      peek(UART_TX_REG_OUT, v);
      check_val("busy_stat", v, 32'h0000_03A5);
      check_val("busy_irq", {31'd0, irq}, 32'd0);
      repeat (8) cyc();
      pulse_done();
      peek(UART_TX_REG_OUT, v);
      check_val("gap_stat", v, 32'h0000_03A5);
      cyc();
      peek(UART_TX_REG_OUT, v);
      check_val("idle_stat", v, 32'h0000_02A5);
      check_val("idle_irq", {31'd0, irq}, 32'd1);

      // Overflow: six writes with the engine stalled, sixth is dropped
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h122);
      exp_q.push_back(9'h033);
      exp_q.push_back(9'h144);
      exp_q.push_back(9'h055);
      bus_write(UART_TX_REG_IN, 32'h0000_0011);
      bus_write(UART_TX_REG_IN, 32'h0000_0122);
      bus_write(UART_TX_REG_IN, 32'h0000_0033);
      bus_write(UART_TX_REG_IN, 32'h0000_0144);
      bus_write(UART_TX_REG_IN, 32'h0000_0055);
      bus_write(UART_TX_REG_IN, 32'h0000_0166);
      bus_read(UART_TX_REG_OUT, v);
      check_val("ovf_stat", v, 32'h0000_4D11);
      bus_read(UART_TX_REG_OUT, v);
      check_val("ovf_cleared", v, 32'h0000_4511);
      check_val("full_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         pulse_done();
         repeat (6) cyc();
      end
      peek(UART_TX_REG_OUT, v);
      check_val("drained_stat", v, 32'h0000_0255);

      // Writes to non-TX registers are ignored; unmapped reads are zero
      bus_write(UART_RX_REG_OUT, 32'h0000_0FFF);
      bus_write(UART_TX_REG_OUT, 32'h0000_0FFF);
      bus_write(2'b00, 32'h0000_01FF);
      repeat (3) cyc();
      peek(UART_TX_REG_OUT, v);
      check_val("wr_ignored_tx", v, 32'h0000_0255);
      peek(UART_RX_REG_OUT, v);
      check_val("wr_ignored_rx", v, 32'h0);
      peek(UART_TX_REG_IN, v);
      check_val("rd_addr01", v, 32'h0);

      // RX capture and read-to-clear
      rx_frame(9'h155, 1'b0);
      bus_read(UART_RX_REG_OUT, v);
      check_val("rx_first", v, 32'h0000_0555);
      bus_read(UART_RX_REG_OUT, v);
      check_val("rx_reread", v, 32'h0000_0155);

      // Overrun, then a clearing read coincident with a new frame
      rx_frame(9'h0AA, 1'b0);
      rx_frame(9'h1CC, 1'b1);
      peek(UART_RX_REG_OUT, v);
      check_val("rx_overrun", v, 32'h0000_0FCC);
      rx_data = 9'h033;
      rx_parity_err = 1'b0;
      rx_done = 1'b1;
      bus.addr = UART_RX_REG_OUT;
      bus.rd_en = 1'b1;
      #1;
      check_val("rx_coinc_read", bus.rdata, 32'h0000_0FCC);
      cyc();
      bus.rd_en = 1'b0;
      rx_done = 1'b0;
      peek(UART_RX_REG_OUT, v);
      check_val("rx_coinc_after", v, 32'h0000_0433);
      check_val("rx_irq", {31'd0, irq}, 32'd1);
      bus_read(UART_RX_REG_OUT, v);
      peek(UART_RX_REG_OUT, v);
      check_val("rx_cleared", v, 32'h0000_0033);

      // Asynchronous reset while BUSY with two entries queued
      exp_q.push_back(9'h0A1);
      bus_write(UART_TX_REG_IN, 32'h0000_00A1);
      bus_write(UART_TX_REG_IN, 32'h0000_00B2);
      bus_write(UART_TX_REG_IN, 32'h0000_00C3);
      repeat (2) cyc();
      peek(UART_TX_REG_OUT, v);
      check_val("pre_rst_stat", v, 32'h0000_21A1);
      reset = 1'b0;
      peek(UART_TX_REG_OUT, v);
      check_val("async_rst_stat", v, 32'h0000_0200);
      check_val("async_rst_state", 32'(dbg_tx_state), 32'(IDLE));
      check_val("async_rst_start", {31'd0, tx_start}, 32'd0);
      check_val("async_rst_data", {24'd0, tx_data}, 32'h0);
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      pulse_done();
      repeat (3) cyc();
      check_val("done_ignored_state", 32'(dbg_tx_state), 32'(IDLE));
      peek(UART_TX_REG_OUT, v);
      check_val("done_ignored_stat", v, 32'h0000_0200);

      check_val("start_count", 32'(n_start), 32'd7);
      check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
